// File: rtl/rounder_ctrl.sv
// rounder_ctrl: multi-cycle sequencer for the FPU rounding stage.
// It accepts an unrounded operand, then normalises, rounds and post-normalises it.
// It returns a packed IEEE single/double result with OVF/UNF/INX flags.
module rounder_ctrl (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               s_in,
  input  logic signed [12:0] er,
  input  logic        [55:0] fr,
  input  logic        [5:0]  lz,
  input  logic               db,
  input  logic        [1:0]  rm,
  input  logic               OVFen,
  input  logic               UNFen,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               s_out,
  output logic        [10:0] e_out,
  output logic        [51:0] f_out,
  output logic               OVF,
  output logic               UNF,
  output logic               INX
);

  typedef enum logic [2:0] {IDLE, NORM, ROUND, POST, DONE} state_t;

  state_t state, state_n;

  function automatic logic signed [12:0] emax_of(input logic d);
    return d ? 13'sd1023 : 13'sd127;
  endfunction

  function automatic logic signed [12:0] alpha_of(input logic d);
    return d ? 13'sd1536 : 13'sd192;
  endfunction

  // Round {hidden, fraction} at the format lsb; returns {inexact, carry, hidden, fraction[51:0]}.
  // For single, the 23-bit fraction sits at [51:29] so both formats share one layout.
  function automatic logic [54:0] round_sig(input logic [55:0] g, input logic stk,
                                            input logic d, input logic [1:0] mode,
                                            input logic s);
    logic [53:0] base, unit;
    logic        lsb, grd, st, inc;
    if (d) begin
      base = {1'b0, g[55:3]};
      unit = 54'd1;
      lsb  = g[3];
      grd  = g[2];
      st   = (|g[1:0]) | stk;
    end else begin
      base = {1'b0, g[55:32], 29'd0};
      unit = 54'd1 << 29;
      lsb  = g[32];
      grd  = g[31];
      st   = (|g[30:0]) | stk;
    end
    case (mode)
      2'b00:   inc = grd & (st | lsb);
      2'b01:   inc = 1'b0;
      2'b10:   inc = ~s & (grd | st);
      default: inc = s & (grd | st);
    endcase
    return {grd | st, base + (inc ? unit : 54'd0)};
  endfunction

  // Post-normalise, bias and saturate; returns {e[10:0], f[51:0], ovf, unf, inx}.
  function automatic logic [65:0] post_fix(input logic [53:0] m, input logic signed [12:0] ex,
                                           input logic tiny, input logic d,
                                           input logic [1:0] mode, input logic s,
                                           input logic ovfen, input logic unfen,
                                           input logic inx);
    logic        [53:0] mm;
    logic signed [12:0] e, eb, emax, alpha;
    logic        [51:0] f, fmax;
    logic               ovf, unf, ix, to_inf;
    emax  = emax_of(d);
    alpha = alpha_of(d);
    fmax  = d ? {52{1'b1}} : {{23{1'b1}}, 29'd0};
    mm    = m;
    e     = ex;
    if (mm[53]) begin
      mm = mm >> 1;
      e  = e + 13'sd1;
    end
    f  = mm[51:0];
    // A zero hidden bit means a denormal or zero result: exponent field 0.
    // A denormal that rounded up into the hidden bit has e == emin, giving eb == 1.
    eb  = mm[52] ? e + emax : 13'sd0;
    ovf = mm[52] & (e > emax);
    ix  = inx;
    unf = 1'b0;
    to_inf = (mode == 2'b00) | ((mode == 2'b10) & ~s) | ((mode == 2'b11) & s);
    if (ovf) begin
      if (ovfen) begin
        eb = eb - alpha;
      end else begin
        ix = 1'b1;
        if (to_inf) begin
          eb = d ? 13'sd2047 : 13'sd255;
          f  = 52'd0;
        end else begin
          eb = d ? 13'sd2046 : 13'sd254;
          f  = fmax;
        end
      end
    end
    if (unfen) begin
      unf = tiny;
      if (tiny) eb = eb + alpha;
    end else begin
      unf = tiny & ix;
    end
    return {eb[10:0], f, ovf, unf, ix};
  endfunction

  // captured operand
  logic               s_p0, db_p0, ovfen_p0, unfen_p0;
  logic signed [12:0] er_p0;
  logic        [55:0] fr_p0;
  logic        [5:0]  lz_p0;
  logic        [1:0]  rm_p0;

  // normalise results
  logic        [55:0] g_p1;
  logic signed [12:0] exp_p1;
  logic               stk_p1, tiny_p1;

  // round results
  logic        [53:0] m_p2;
  logic               inx_p2;

  logic signed [12:0] emin_n, en_n, dist_n, negd_n, exp_n;
  logic        [5:0]  shl_n, shr_n;
  logic        [119:0] wide_n;
  logic        [55:0] g_n;
  logic               zero_n, tiny_n, den_n, stk_n;
  logic        [54:0] rnd_n;
  logic        [65:0] post_n;

  assign in_ready = (state == IDLE);

  // Normalise: left-justify, or align to emin for gradual underflow (sticky collects lost bits)
  always_comb begin
    emin_n = 13'sd1 - emax_of(db_p0);
    en_n   = er_p0 - $signed({7'd0, lz_p0});
    zero_n = (fr_p0 == 56'd0);
    tiny_n = ~zero_n & (en_n < emin_n);
    den_n  = tiny_n & ~unfen_p0;
    dist_n = er_p0 - emin_n;
    negd_n = emin_n - er_p0;
    shl_n  = den_n ? dist_n[5:0] : lz_p0;
    shr_n  = (negd_n > 13'sd63) ? 6'd63 : negd_n[5:0];
    wide_n = {fr_p0, 64'd0} >> shr_n;
    g_n    = fr_p0 << shl_n;
    stk_n  = 1'b0;
    exp_n  = en_n;
    if (den_n) begin
      exp_n = emin_n;
      if (dist_n < 13'sd0) begin
        g_n   = wide_n[119:64];
        stk_n = |wide_n[63:0];
      end
    end
  end

  // Round and post-normalise on the held stage registers
  always_comb begin
    rnd_n  = round_sig(g_p1, stk_p1, db_p0, rm_p0, s_p0);
    post_n = post_fix(m_p2, exp_p1, tiny_p1, db_p0, rm_p0, s_p0, ovfen_p0, unfen_p0, inx_p2);
  end

  // Next-state sequencing: one operation in flight
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = NORM;
      NORM:    state_n = ROUND;
      ROUND:   state_n = POST;
      POST:    state_n = DONE;
      DONE:    if (out_valid && out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Control registers; the result is presented one cycle after it lands in DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      state     <= state_n;
      out_valid <= (state == DONE) && !(out_valid && out_ready);
    end
  end

  // Result registers, loaded at the end of POST and held through DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_out <= 1'b0;
      e_out <= 11'd0;
      f_out <= 52'd0;
      OVF   <= 1'b0;
      UNF   <= 1'b0;
      INX   <= 1'b0;
    end else if (state == POST) begin
      s_out <= s_p0;
      {e_out, f_out, OVF, UNF, INX} <= post_n;
    end
  end

  // Stage datapath registers, no reset
  always_ff @(posedge clk) begin
    // IDLE -> NORM: capture operand
    if (state == IDLE && in_valid) begin
      s_p0     <= s_in;
      er_p0    <= er;
      fr_p0    <= fr;
      lz_p0    <= lz;
      db_p0    <= db;
      rm_p0    <= rm;
      ovfen_p0 <= OVFen;
      unfen_p0 <= UNFen;
    end
    // NORM -> ROUND: shifted significand
    if (state == NORM) begin
      g_p1    <= g_n;
      exp_p1  <= exp_n;
      stk_p1  <= stk_n;
      tiny_p1 <= tiny_n;
    end
    // ROUND -> POST: rounded significand
    if (state == ROUND) begin
      inx_p2 <= rnd_n[54];
      m_p2   <= rnd_n[53:0];
    end
  end

endmodule

// File: tb/tb_rounder_ctrl.sv
// Bench for rounder_ctrl: directed cases plus random operands checked against an
// exact quantum-based rounding model.
module tb_rounder_ctrl;

  logic               clk = 1'b0;
  logic               rst, in_valid, in_ready, s_in, db, OVFen, UNFen;
  logic               out_valid, out_ready, s_out, OVF, UNF, INX;
  logic signed [12:0] er;
  logic        [55:0] fr;
  logic        [5:0]  lz;
  logic        [1:0]  rm;
  logic        [10:0] e_out;
  logic        [51:0] f_out;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        s;
    logic [10:0] e;
    logic [51:0] f;
    logic        ovf;
    logic        unf;
    logic        inx;
  } res_t;

  rounder_ctrl dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .s_in(s_in), .er(er), .fr(fr), .lz(lz), .db(db), .rm(rm),
    .OVFen(OVFen), .UNFen(UNFen), .out_valid(out_valid), .out_ready(out_ready),
    .s_out(s_out), .e_out(e_out), .f_out(f_out), .OVF(OVF), .UNF(UNF), .INX(INX)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_assert++;
    assert (obs === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, want);
    end
  endtask

  function automatic res_t mk(input logic s, input logic [10:0] e, input logic [51:0] f,
                              input logic o, input logic u, input logic i);
    res_t r;
    r.s = s; r.e = e; r.f = f; r.ovf = o; r.unf = u; r.inx = i;
    return r;
  endfunction

  function automatic logic [5:0] lzc(input logic [55:0] v);
    logic [5:0] n;
    n = 6'd0;
    for (int i = 0; i < 56; i++) if (v[i]) n = 6'(55 - i);
    return n;
  endfunction

  // Exact model: value = fr * 2^(er-55). Pick the result quantum 2^q, form the
  // integer multiple N and remainder, round, then pack and apply exception rules.
  function automatic res_t model(input logic s, input int erv, input logic [55:0] f56,
                                 input logic d, input logic [1:0] mode,
                                 input logic ovfen, input logic unfen);
    res_t         r;
    int           emax, emin, alpha, p, msb, en, ee, q, sh, k, eb;
    logic [127:0] wide, nn, rem, half, pmask, frac;
    logic         tiny, exact, up, normal, ovf, unf, inx, gt, eq;
    r = '0;
    r.s = s;
    if (f56 == 56'd0) return r;
    emax  = d ? 1023 : 127;
    emin  = 1 - emax;
    alpha = d ? 1536 : 192;
    p     = d ? 52 : 23;
    msb   = 0;
    for (int i = 0; i < 56; i++) if (f56[i]) msb = i;
    en    = erv - (55 - msb);
    tiny  = (en < emin);
    ee    = (tiny && !unfen) ? emin : en;
    q     = ee - p;
    sh    = erv - 55 - q;
    wide  = 128'(f56);
    gt = 1'b0; eq = 1'b0; exact = 1'b1;
    if (sh >= 0) begin
      nn = wide << sh;
    end else begin
      k = -sh;
      if (k > 120) begin
        nn = '0; exact = 1'b0;
      end else begin
        nn    = wide >> k;
        rem   = wide & ((128'd1 << k) - 128'd1);
        half  = 128'd1 << (k - 1);
        exact = (rem == '0);
        gt    = (rem > half);
        eq    = (rem == half);
      end
    end
    case (mode)
      2'b00:   up = gt || (eq && nn[0]);
      2'b01:   up = 1'b0;
      2'b10:   up = !s && !exact;
      default: up = s && !exact;
    endcase
    nn = nn + 128'(up);
    if (nn[p+1]) begin
      nn = nn >> 1;
      ee = ee + 1;
    end
    inx    = !exact;
    normal = nn[p];
    eb     = normal ? ee + emax : 0;
    pmask  = (128'd1 << p) - 128'd1;
    frac   = nn & pmask;
    ovf    = normal && (ee > emax);
    unf    = 1'b0;
    if (ovf) begin
      if (ovfen) eb = eb - alpha;
      else begin
        inx = 1'b1;
        if (mode == 2'b00 || (mode == 2'b10 && !s) || (mode == 2'b11 && s)) begin
          eb = 2 * emax + 1; frac = '0;
        end else begin
          eb = 2 * emax; frac = pmask;
        end
      end
    end
    if (unfen) begin
      unf = tiny;
      if (tiny) eb = eb + alpha;
    end else begin
      unf = tiny && inx;
    end
    r.e   = 11'(eb);
    r.f   = d ? frac[51:0] : (frac[51:0] << 29);
    r.ovf = ovf;
    r.unf = unf;
    r.inx = inx;
    return r;
  endfunction

  task automatic scramble();
    s_in = 1'($urandom); er = 13'($urandom); fr = {$urandom, 24'($urandom)};
    lz = 6'($urandom); db = 1'($urandom); rm = 2'($urandom);
    OVFen = 1'($urandom); UNFen = 1'($urandom);
  endtask

  task automatic do_op(input string tag, input logic s, input int erv, input logic [55:0] f56,
                       input logic d, input logic [1:0] mode, input logic oe, input logic ue,
                       input res_t want, input int hold);
    int w, lat;
    w = 0;
    @(negedge clk);
    while (in_ready !== 1'b1 && w < 20) begin @(negedge clk); w++; end
    chk({tag, "_ready"}, 64'(in_ready), 64'd1);
    s_in = s; er = 13'(erv); fr = f56; lz = lzc(f56); db = d; rm = mode;
    OVFen = oe; UNFen = ue; in_valid = 1'b1;
    @(negedge clk);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 12) begin
      scramble();
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    chk({tag, "_latency"}, 64'(lat), 64'd4);
    chk({tag, "_s"}, 64'(s_out), 64'(want.s));
    chk({tag, "_e"}, 64'(e_out), 64'(want.e));
    chk({tag, "_f"}, 64'(f_out), 64'(want.f));
    chk({tag, "_flags"}, 64'({OVF, UNF, INX}), 64'({want.ovf, want.unf, want.inx}));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_ctl"}, 64'({out_valid, in_ready, s_out, e_out, OVF, UNF, INX}),
          64'({1'b1, 1'b0, want.s, want.e, want.ovf, want.unf, want.inx}));
      chk({tag, "_hold_f"}, 64'(f_out), 64'(want.f));
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_handoff"}, 64'({out_valid, in_ready}), 64'd1);
  endtask

  initial begin
    logic [63:0] raw;
    logic [55:0] f56;
    int          erv, emaxv, eminv, lzr, tz;
    logic        d, s, oe, ue;
    logic [1:0]  mode;
    res_t        want;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    s_in = 1'b0; er = '0; fr = '0; lz = '0; db = 1'b0; rm = 2'b00; OVFen = 1'b0; UNFen = 1'b0;
    #22;
    chk("reset_ctl", 64'({in_ready, out_valid}), 64'd2);
    chk("reset_data", 64'({s_out, e_out, OVF, UNF, INX}), 64'd0);
    chk("reset_f", 64'(f_out), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    do_op("one_single", 1'b0, 0, 56'h80000000000000, 1'b0, 2'b00, 1'b0, 1'b0,
          mk(1'b0, 11'd127, 52'd0, 1'b0, 1'b0, 1'b0), 3);
    do_op("tie_rne_dbl", 1'b0, 0, 56'h8000000000000C, 1'b1, 2'b00, 1'b0, 1'b0,
          mk(1'b0, 11'd1023, 52'h2, 1'b0, 1'b0, 1'b1), 0);
    do_op("tie_rz_dbl", 1'b0, 0, 56'h8000000000000C, 1'b1, 2'b01, 1'b0, 1'b0,
          mk(1'b0, 11'd1023, 52'h1, 1'b0, 1'b0, 1'b1), 0);
    do_op("carry_single", 1'b0, 0, 56'hFFFFFF80000000, 1'b0, 2'b00, 1'b0, 1'b0,
          mk(1'b0, 11'd128, 52'd0, 1'b0, 1'b0, 1'b1), 1);
    do_op("ovf_rne", 1'b0, 128, 56'h80000000000000, 1'b0, 2'b00, 1'b0, 1'b0,
          mk(1'b0, 11'd255, 52'd0, 1'b1, 1'b0, 1'b1), 0);
    do_op("ovf_rz", 1'b0, 128, 56'h80000000000000, 1'b0, 2'b01, 1'b0, 1'b0,
          mk(1'b0, 11'd254, 52'hFFFFFE0000000, 1'b1, 1'b0, 1'b1), 0);
    do_op("ovf_ru_neg", 1'b1, 128, 56'h80000000000000, 1'b0, 2'b10, 1'b0, 1'b0,
          mk(1'b1, 11'd254, 52'hFFFFFE0000000, 1'b1, 1'b0, 1'b1), 0);
    do_op("ovf_trap", 1'b0, 128, 56'h80000000000000, 1'b0, 2'b00, 1'b1, 1'b0,
          mk(1'b0, 11'd63, 52'd0, 1'b1, 1'b0, 1'b0), 0);
    do_op("denorm_exact", 1'b0, -130, 56'h80000000000000, 1'b0, 2'b00, 1'b0, 1'b0,
          mk(1'b0, 11'd0, 52'h1000000000000, 1'b0, 1'b0, 1'b0), 0);
    do_op("denorm_trap", 1'b0, -130, 56'h80000000000000, 1'b0, 2'b00, 1'b0, 1'b1,
          mk(1'b0, 11'd189, 52'd0, 1'b0, 1'b1, 1'b0), 0);
    do_op("neg_zero", 1'b1, 50, 56'd0, 1'b1, 2'b00, 1'b0, 1'b0,
          mk(1'b1, 11'd0, 52'd0, 1'b0, 1'b0, 1'b0), 0);

    // Reset pulsed while the operation sits in ROUND
    @(negedge clk);
    s_in = 1'b0; er = 13'sd0; fr = 56'h80000000000000; lz = 6'd0; db = 1'b0; rm = 2'b00;
    OVFen = 1'b0; UNFen = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_ctl", 64'({in_ready, out_valid}), 64'd2);
    chk("rst_async_data", 64'({s_out, e_out, OVF, UNF, INX}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_discard", 64'({in_ready, out_valid}), 64'd2);

    for (int n = 0; n < 200; n++) begin
      d = 1'($urandom); s = 1'($urandom); mode = 2'($urandom);
      oe = 1'($urandom); ue = 1'($urandom);
      emaxv = d ? 1023 : 127;
      eminv = 1 - emaxv;
      case ($urandom_range(0, 3))
        0:       erv = emaxv - 3 + int'($urandom_range(0, 60));
        1:       erv = eminv - 60 + int'($urandom_range(0, 120));
        2:       erv = int'($urandom_range(0, 40)) - 20;
        default: erv = eminv - 150 + int'($urandom_range(0, 100));
      endcase
      raw = {$urandom, $urandom};
      lzr = int'($urandom_range(0, 55));
      tz  = int'($urandom_range(0, 55));
      f56 = (raw[55:0] | 56'h80000000000000) >> lzr;
      if ($urandom_range(0, 1) == 0) f56 = f56 & ~((56'd1 << tz) - 56'd1);
      if ($urandom_range(0, 15) == 0) f56 = 56'd0;
      want = model(s, erv, f56, d, mode, oe, ue);
      do_op("rnd", s, erv, f56, d, mode, oe, ue, want, int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
